mem_port_arbiter: RTL and testbench

- Shares one single-port synchronous RAM between the instruction-fetch stage (read-only requester) and the memory stage (read/write requester).
- Arbitrates between the two, sequences each access through a fixed-latency RAM, and returns read data with a one-cycle ready pulse.
- Sits between the pipeline stages and the unified memory. Pipeline stall logic uses the level of each request together with the absence of its ready pulse.

---
 rtl/mem_port_arbiter_if.sv | 38 +++
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester, RAM and status signals of the shared memory port.
// The arbiter takes the slave side; requesters and RAM model take the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  ram_en;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  logic                  busy;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_ready, if_rdata, mem_ready, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_ready, if_rdata, mem_ready, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between fetch (read-only) and data (read/write) requesters.
// Ready pulses 2+MEM_LATENCY cycles after the request is seen in IDLE; losers simply hold their request.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_LATENCY     = 2,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int STREAK_W = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CNT_W-1:0]    LAT_INIT   = CNT_W'(MEM_LATENCY);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_t;

  state_t                state_q,     state_d;
  owner_t                owner_q,     owner_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [STREAK_W-1:0]   streak_q,    streak_d;
  logic                  ram_en_q,    ram_en_d;
  logic                  ram_we_q,    ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic                  if_ready_q,  if_ready_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [DATA_WIDTH-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic                  busy_q,      busy_d;
  logic                  grant_data;

  // Data has priority unless fetch has already been passed over MAX_DATA_STREAK times.
  assign grant_data = bus.mem_req && !(bus.if_req && (streak_q == STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    ram_en_d    = 1'b0;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_ready_d  = 1'b0;
    mem_ready_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus.mem_req || bus.if_req) begin
          // The RAM-side registers double as the latched request for the whole access.
          state_d  = ISSUE;
          ram_en_d = 1'b1;
          if (grant_data) begin
            owner_d     = OWN_DATA;
            ram_we_d    = bus.mem_we;
            ram_addr_d  = bus.mem_addr;
            ram_wdata_d = bus.mem_wdata;
            if (!bus.if_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + STREAK_W'(1);
            end
          end else begin
            owner_d     = OWN_FETCH;
            ram_we_d    = 1'b0;
            ram_addr_d  = bus.if_addr;
            ram_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = LAT_INIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = RESP;
          if (owner_q == OWN_DATA) begin
            mem_ready_d = 1'b1;
            if (!ram_we_q) begin
              mem_rdata_d = bus.ram_rdata;
            end
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = bus.ram_rdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= OWN_FETCH;
      cnt_q       <= '0;
      streak_q    <= '0;
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      ram_en_q    <= ram_en_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.ram_en    = ram_en_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_wdata = ram_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
// Three instances cover MEM_LATENCY 2 (main), 1 and 5.
module tb_mem_port_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus5 ();

  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(2), .MAX_DATA_STREAK(MAXS))
    u_dut (.clk(clk), .reset(reset), .bus(bus2));
  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(1), .MAX_DATA_STREAK(MAXS))
    u_dut_l1 (.clk(clk), .reset(reset), .bus(bus1));
  mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_LATENCY(5), .MAX_DATA_STREAK(MAXS))
    u_dut_l5 (.clk(clk), .reset(reset), .bus(bus5));

  function automatic logic [31:0] init_word(input int idx);
    return 32'hA5A5_0000 ^ 32'(idx * 7);
  endfunction

  // RAM environment: read data is driven only in the cycle it is valid, garbage otherwise.
  logic [DW-1:0] mem2 [1024];
  int            rd_cnt2 = 0, rd_cnt1 = 0, rd_cnt5 = 0;
  logic [DW-1:0] rd_val2, rd_val1, rd_val5;

  always @(posedge clk) begin
    if (bus2.ram_en) begin
      rd_cnt2 <= 2;
      rd_val2 <= mem2[bus2.ram_addr[11:2]];
      if (bus2.ram_we) mem2[bus2.ram_addr[11:2]] = bus2.ram_wdata;
    end else if (rd_cnt2 > 0) rd_cnt2 <= rd_cnt2 - 1;
    if (bus1.ram_en) begin
      rd_cnt1 <= 1;
      rd_val1 <= init_word(int'(bus1.ram_addr[11:2]));
    end else if (rd_cnt1 > 0) rd_cnt1 <= rd_cnt1 - 1;
    if (bus5.ram_en) begin
      rd_cnt5 <= 5;
      rd_val5 <= init_word(int'(bus5.ram_addr[11:2]));
    end else if (rd_cnt5 > 0) rd_cnt5 <= rd_cnt5 - 1;
  end

  assign bus2.ram_rdata = (rd_cnt2 == 1) ? rd_val2 : 32'hBAD0_BAD0;
  assign bus1.ram_rdata = (rd_cnt1 == 1) ? rd_val1 : 32'hBAD1_BAD1;
  assign bus5.ram_rdata = (rd_cnt5 == 1) ? rd_val5 : 32'hBAD5_BAD5;

  // Reference model state
  logic [DW-1:0] shadow [1024];
  int            streak_m;
  logic [DW-1:0] exp_if_rdata, exp_mem_rdata;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus2.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%h want=0", bus2.busy); end
    checks++; if (bus2.ram_en !== 1'b0 || bus2.ram_we !== 1'b0) begin failures++; $display("FAIL reset_ram_ctl got=%b%b want=00", bus2.ram_en, bus2.ram_we); end
    checks++; if (bus2.ram_addr !== '0 || bus2.ram_wdata !== '0) begin failures++; $display("FAIL reset_ram_bus got=%h/%h want=0/0", bus2.ram_addr, bus2.ram_wdata); end
    checks++; if (bus2.if_ready !== 1'b0 || bus2.mem_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b%b want=00", bus2.if_ready, bus2.mem_ready); end
    checks++; if (bus2.if_rdata !== '0 || bus2.mem_rdata !== '0) begin failures++; $display("FAIL reset_rdata got=%h/%h want=0/0", bus2.if_rdata, bus2.mem_rdata); end
    checks++; if (bus1.busy !== 1'b0 || bus5.busy !== 1'b0) begin failures++; $display("FAIL reset_busy_sweep got=%b%b want=00", bus1.busy, bus5.busy); end
    reset = 1'b0;
    streak_m = 0; exp_if_rdata = '0; exp_mem_rdata = '0;
    step();
    checks++; if (bus2.busy !== 1'b0) begin failures++; $display("FAIL idle_no_req_busy got=%h want=0", bus2.busy); end
  endtask

  task automatic test_single_fetch();
    bus2.if_req = 1'b1; bus2.if_addr = 32'h100;
    streak_m = 0; exp_if_rdata = shadow[64];
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (bus2.ram_en !== (c == 1)) begin failures++; $display("FAIL fetch_ram_en c=%0d got=%b want=%b", c, bus2.ram_en, (c == 1)); end
      if (c == 1) begin
        checks++; if (bus2.ram_addr !== 32'h100 || bus2.ram_we !== 1'b0) begin failures++; $display("FAIL fetch_ram_addr got=%h we=%b want=100 we=0", bus2.ram_addr, bus2.ram_we); end
      end
      checks++; if (bus2.if_ready !== (c == 4) || bus2.mem_ready !== 1'b0) begin failures++; $display("FAIL fetch_ready c=%0d got=%b%b want=%b0", c, bus2.if_ready, bus2.mem_ready, (c == 4)); end
      checks++; if (bus2.busy !== (c <= 4)) begin failures++; $display("FAIL fetch_busy c=%0d got=%b want=%b", c, bus2.busy, (c <= 4)); end
      if (c >= 4) begin
        checks++; if (bus2.if_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch_rdata c=%0d got=%h want=deadbeef", c, bus2.if_rdata); end
        bus2.if_req = 1'b0;
      end
    end
  endtask

  task automatic test_data_write();
    bus2.mem_req = 1'b1; bus2.mem_we = 1'b1; bus2.mem_addr = 32'h200; bus2.mem_wdata = 32'h1234_5678;
    shadow[128] = 32'h1234_5678; streak_m = 0;
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (bus2.ram_en !== (c == 1)) begin failures++; $display("FAIL wr_ram_en c=%0d got=%b want=%b", c, bus2.ram_en, (c == 1)); end
      if (c == 1) begin
        checks++; if (bus2.ram_we !== 1'b1 || bus2.ram_addr !== 32'h200 || bus2.ram_wdata !== 32'h1234_5678) begin failures++; $display("FAIL wr_ram_bus got=%b/%h/%h want=1/200/12345678", bus2.ram_we, bus2.ram_addr, bus2.ram_wdata); end
      end
      checks++; if (bus2.mem_ready !== (c == 4) || bus2.if_ready !== 1'b0) begin failures++; $display("FAIL wr_ready c=%0d got=%b%b want=%b0", c, bus2.mem_ready, bus2.if_ready, (c == 4)); end
      if (c == 4) begin
        checks++; if (bus2.mem_rdata !== exp_mem_rdata) begin failures++; $display("FAIL wr_rdata_held got=%h want=%h", bus2.mem_rdata, exp_mem_rdata); end
        bus2.mem_req = 1'b0; bus2.mem_we = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous();
    bus2.if_req = 1'b1; bus2.if_addr = 32'h300;
    bus2.mem_req = 1'b1; bus2.mem_we = 1'b0; bus2.mem_addr = 32'h40;
    exp_mem_rdata = shadow[16]; exp_if_rdata = shadow[192];
    for (int c = 1; c <= 10; c++) begin
      step();
      checks++; if (bus2.ram_en !== (c == 1 || c == 6)) begin failures++; $display("FAIL sim_ram_en c=%0d got=%b", c, bus2.ram_en); end
      if (c == 1) begin
        checks++; if (bus2.ram_addr !== 32'h40) begin failures++; $display("FAIL sim_first_addr got=%h want=40", bus2.ram_addr); end
      end
      if (c == 6) begin
        checks++; if (bus2.ram_addr !== 32'h300 || bus2.ram_we !== 1'b0) begin failures++; $display("FAIL sim_second_addr got=%h we=%b want=300 we=0", bus2.ram_addr, bus2.ram_we); end
      end
      checks++; if (bus2.mem_ready !== (c == 4) || bus2.if_ready !== (c == 9)) begin failures++; $display("FAIL sim_ready c=%0d got=%b%b", c, bus2.mem_ready, bus2.if_ready); end
      checks++; if (bus2.busy !== (c != 5 && c != 10)) begin failures++; $display("FAIL sim_busy c=%0d got=%b", c, bus2.busy); end
      if (c == 4) begin
        checks++; if (bus2.mem_rdata !== exp_mem_rdata) begin failures++; $display("FAIL sim_mem_rdata got=%h want=%h", bus2.mem_rdata, exp_mem_rdata); end
        bus2.mem_req = 1'b0;
      end
      if (c == 9) begin
        checks++; if (bus2.if_rdata !== exp_if_rdata) begin failures++; $display("FAIL sim_if_rdata got=%h want=%h", bus2.if_rdata, exp_if_rdata); end
        bus2.if_req = 1'b0;
      end
    end
    streak_m = 0;
  endtask

  task automatic test_starvation();
    byte seq [$];
    int  pulse_cyc [$];
    bus2.if_req = 1'b1; bus2.if_addr = 32'h104;
    bus2.mem_req = 1'b1; bus2.mem_we = 1'b0; bus2.mem_addr = 32'h44;
    for (int c = 1; c <= 40 && seq.size() < 6; c++) begin
      step();
      checks++; if (bus2.if_ready === 1'b1 && bus2.mem_ready === 1'b1) begin failures++; $display("FAIL starve_both_ready c=%0d", c); end
      if (bus2.mem_ready === 1'b1) begin
        seq.push_back("D"); pulse_cyc.push_back(c);
        checks++; if (bus2.mem_rdata !== shadow[17]) begin failures++; $display("FAIL starve_mem_rdata got=%h want=%h", bus2.mem_rdata, shadow[17]); end
      end else if (bus2.if_ready === 1'b1) begin
        seq.push_back("F"); pulse_cyc.push_back(c);
        checks++; if (bus2.if_rdata !== shadow[65]) begin failures++; $display("FAIL starve_if_rdata got=%h want=%h", bus2.if_rdata, shadow[65]); end
      end
    end
    bus2.if_req = 1'b0; bus2.mem_req = 1'b0;
    exp_mem_rdata = shadow[17]; exp_if_rdata = shadow[65];
    streak_m = 1;
    checks++;
    if (seq.size() != 6) begin
      failures++; $display("FAIL starve_pulse_count got=%0d want=6 (cycle budget expired)", seq.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        byte want;
        want = (i == 4) ? "F" : "D";
        checks++; if (seq[i] != want) begin failures++; $display("FAIL starve_order idx=%0d got=%c want=%c", i, seq[i], want); end
        checks++; if (pulse_cyc[i] != 4 + 5 * i) begin failures++; $display("FAIL starve_timing idx=%0d got=%0d want=%0d", i, pulse_cyc[i], 4 + 5 * i); end
      end
    end
    step();
    checks++; if (bus2.busy !== 1'b0) begin failures++; $display("FAIL starve_end_busy got=%b want=0", bus2.busy); end
  endtask

  task automatic test_reset_mid();
    bus2.mem_req = 1'b1; bus2.mem_we = 1'b0; bus2.mem_addr = 32'h80;
    step(); step();
    reset = 1'b1;
    #1;
    checks++; if (bus2.busy !== 1'b0 || bus2.ram_en !== 1'b0 || bus2.ram_we !== 1'b0) begin failures++; $display("FAIL rstmid_ctl got=%b%b%b want=000", bus2.busy, bus2.ram_en, bus2.ram_we); end
    checks++; if (bus2.ram_addr !== '0 || bus2.ram_wdata !== '0) begin failures++; $display("FAIL rstmid_ram_bus got=%h/%h want=0/0", bus2.ram_addr, bus2.ram_wdata); end
    checks++; if (bus2.if_rdata !== '0 || bus2.mem_rdata !== '0 || bus2.if_ready !== 1'b0 || bus2.mem_ready !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got=%h/%h/%b%b want=0/0/00", bus2.if_rdata, bus2.mem_rdata, bus2.if_ready, bus2.mem_ready); end
    bus2.mem_req = 1'b0;
    step();
    reset = 1'b0;
    streak_m = 0; exp_if_rdata = '0; exp_mem_rdata = '0;
    for (int c = 1; c <= 4; c++) begin
      step();
      checks++; if (bus2.mem_ready !== 1'b0 || bus2.if_ready !== 1'b0 || bus2.busy !== 1'b0) begin failures++; $display("FAIL rstmid_quiet c=%0d got=%b%b%b want=000", c, bus2.mem_ready, bus2.if_ready, bus2.busy); end
    end
    bus2.mem_req = 1'b1; bus2.mem_addr = 32'h40;
    exp_mem_rdata = shadow[16];
    for (int c = 1; c <= 5; c++) begin
      step();
      checks++; if (bus2.mem_ready !== (c == 4)) begin failures++; $display("FAIL rstmid_fresh_ready c=%0d got=%b want=%b", c, bus2.mem_ready, (c == 4)); end
      if (c == 4) begin
        checks++; if (bus2.mem_rdata !== exp_mem_rdata) begin failures++; $display("FAIL rstmid_fresh_rdata got=%h want=%h", bus2.mem_rdata, exp_mem_rdata); end
        bus2.mem_req = 1'b0;
      end
    end
  endtask

  task automatic test_latency_sweep();
    int en1 = 0;
    int en5 = 0;
    bus1.mem_req = 1'b1; bus1.mem_we = 1'b0; bus1.mem_addr = 32'h40;
    bus5.if_req = 1'b1; bus5.if_addr = 32'h48;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (bus1.ram_en === 1'b1) en1++;
      if (bus5.ram_en === 1'b1) en5++;
      checks++; if (bus1.mem_ready !== (c == 3) || bus1.busy !== (c <= 3)) begin failures++; $display("FAIL l1_timing c=%0d got=%b%b", c, bus1.mem_ready, bus1.busy); end
      checks++; if (bus5.if_ready !== (c == 7) || bus5.busy !== (c <= 7)) begin failures++; $display("FAIL l5_timing c=%0d got=%b%b", c, bus5.if_ready, bus5.busy); end
      if (c == 3) begin
        checks++; if (bus1.mem_rdata !== init_word(16)) begin failures++; $display("FAIL l1_rdata got=%h want=%h", bus1.mem_rdata, init_word(16)); end
        bus1.mem_req = 1'b0;
      end
      if (c == 7) begin
        checks++; if (bus5.if_rdata !== init_word(18)) begin failures++; $display("FAIL l5_rdata got=%h want=%h", bus5.if_rdata, init_word(18)); end
        bus5.if_req = 1'b0;
      end
    end
    checks++; if (en1 != 1 || en5 != 1) begin failures++; $display("FAIL sweep_ram_en_count got=%0d/%0d want=1/1", en1, en5); end
  endtask

  task automatic test_random();
    bit            if_pend  = 1'b0;
    bit            mem_pend = 1'b0;
    bit            gd, ew;
    logic [AW-1:0] ea;
    int            idx;
    for (int it = 0; it < 80; it++) begin
      if (!if_pend && $urandom_range(0, 1) == 1) begin
        if_pend = 1'b1; bus2.if_req = 1'b1;
        bus2.if_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      end
      if (!mem_pend && $urandom_range(0, 2) != 0) begin
        mem_pend = 1'b1; bus2.mem_req = 1'b1;
        bus2.mem_we = 1'($urandom_range(0, 1));
        bus2.mem_addr = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
        bus2.mem_wdata = $urandom;
      end
      if (!if_pend && !mem_pend) begin
        step();
        checks++; if (bus2.busy !== 1'b0 || bus2.ram_en !== 1'b0) begin failures++; $display("FAIL rnd_idle it=%0d got=%b%b want=00", it, bus2.busy, bus2.ram_en); end
        continue;
      end
      gd = mem_pend && !(if_pend && streak_m == MAXS);
      if (gd && if_pend) streak_m = (streak_m < MAXS) ? streak_m + 1 : MAXS;
      else streak_m = 0;
      ea  = gd ? bus2.mem_addr : bus2.if_addr;
      ew  = gd ? bus2.mem_we : 1'b0;
      idx = int'(ea[11:2]);
      if (gd && ew) shadow[idx] = bus2.mem_wdata;
      else if (gd) exp_mem_rdata = shadow[idx];
      else exp_if_rdata = shadow[idx];
      for (int c = 1; c <= 4; c++) begin
        step();
        checks++; if (bus2.ram_en !== (c == 1)) begin failures++; $display("FAIL rnd_ram_en it=%0d c=%0d got=%b", it, c, bus2.ram_en); end
        if (c == 1) begin
          checks++; if (bus2.ram_addr !== ea || bus2.ram_we !== ew) begin failures++; $display("FAIL rnd_ram_req it=%0d got=%h/%b want=%h/%b", it, bus2.ram_addr, bus2.ram_we, ea, ew); end
          if (gd && ew) begin
            checks++; if (bus2.ram_wdata !== bus2.mem_wdata) begin failures++; $display("FAIL rnd_ram_wdata it=%0d got=%h want=%h", it, bus2.ram_wdata, bus2.mem_wdata); end
          end
        end
        checks++; if (bus2.mem_ready !== (gd && c == 4) || bus2.if_ready !== (!gd && c == 4)) begin failures++; $display("FAIL rnd_ready it=%0d c=%0d got=%b%b grant_data=%b", it, c, bus2.mem_ready, bus2.if_ready, gd); end
        checks++; if (bus2.busy !== 1'b1) begin failures++; $display("FAIL rnd_busy it=%0d c=%0d got=%b want=1", it, c, bus2.busy); end
      end
      checks++; if (bus2.mem_rdata !== exp_mem_rdata || bus2.if_rdata !== exp_if_rdata) begin failures++; $display("FAIL rnd_rdata it=%0d got=%h/%h want=%h/%h", it, bus2.mem_rdata, bus2.if_rdata, exp_mem_rdata, exp_if_rdata); end
      if (gd) begin mem_pend = 1'b0; bus2.mem_req = 1'b0; end
      else begin if_pend = 1'b0; bus2.if_req = 1'b0; end
      step();
      checks++; if (bus2.busy !== 1'b0 || bus2.mem_ready !== 1'b0 || bus2.if_ready !== 1'b0) begin failures++; $display("FAIL rnd_after it=%0d got=%b%b%b want=000", it, bus2.busy, bus2.mem_ready, bus2.if_ready); end
    end
    bus2.if_req = 1'b0; bus2.mem_req = 1'b0;
    step();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem2[i]   = init_word(i);
      shadow[i] = init_word(i);
    end
    mem2[64]   = 32'hDEAD_BEEF;
    shadow[64] = 32'hDEAD_BEEF;
    reset = 1'b1;
    bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.mem_req = 1'b0; bus2.mem_we = 1'b0; bus2.mem_addr = '0; bus2.mem_wdata = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.mem_req = 1'b0; bus1.mem_we = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;
    bus5.if_req = 1'b0; bus5.if_addr = '0; bus5.mem_req = 1'b0; bus5.mem_we = 1'b0; bus5.mem_addr = '0; bus5.mem_wdata = '0;

    test_reset();
    test_single_fetch();
    test_data_write();
    test_simultaneous();
    test_starvation();
    test_reset_mid();
    test_latency_sweep();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
